fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small synchronous FIFO of fetched {pc, inst} pairs between the IF stage (pc + instruction memory output) and the ID stage.
- Decouples fetch from decode stalls; valid/ready handshake on both sides.
- Flush input discards all wrong-path entries on taken branch or PCSrc redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PC_W, `WORD (64), width of stored PC.
- INST_W, `INST_SIZE (32), width of stored instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all entries (branch redirect from EX).
- in_valid  in  1  IF presents a fetched pair.
- in_ready  out  1  queue can accept; equals !full; no combinational dependence on out_ready.
- in_pc  in  PC_W  PC of fetched instruction.
- in_inst  in  INST_W  instruction word.
- out_valid  out  1  head entry available to ID.
- out_ready  in  1  ID consumes head this cycle.
- out_pc  out  PC_W  head PC.
- out_pc_incr  out  PC_W  head PC + 4, modulo 2^PC_W.
- out_inst  out  INST_W  head instruction.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array; wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits. MSB is the wrap bit.
- Empty when pointers are equal. Full when the low bits are equal and the MSBs differ.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- Push writes the entry at wr_ptr and increments wr_ptr. Pop increments rd_ptr. Both wrap naturally.
- count = wr_ptr - rd_ptr (registered pointers, combinational subtract).
- Latency, default build: an entry pushed at edge N is visible on out_* after edge N (one cycle).
- out_valid = !empty. out_pc, out_inst and out_pc_incr read the head combinationally from storage. All three are forced to 0 when empty.
- Simultaneous push and pop when neither full nor empty: both happen; count unchanged.
- When empty: pop impossible. A push on the same cycle as out_ready=1 only enqueues.
- When full: in_ready=0, so no push. A pop the same cycle frees a slot, but in_ready rises only next cycle.
- in_valid while in_ready=0: ignored. IF must hold the pair stable until accepted.
- Flush: at the next edge both pointers are set to 0 and count=0. Flush dominates push and pop in the same cycle. out_valid=0 the cycle after flush.
- Reset (rst=1 at an edge, including mid-operation): pointers=0, count=0, out_valid=0, out_* = 0, in_ready=1. Reset dominates flush, push and pop.
- Storage contents are not reset; they are don't-care when invalid.
- FSM view: EMPTY -> PARTIAL on push; PARTIAL -> FULL when count reaches DEPTH; FULL -> PARTIAL on pop; PARTIAL -> EMPTY when count reaches 0. Any state -> EMPTY on flush or rst.
- DEPTH=2 boundary: full after two pushes with no pop; wrap exercised on the third push.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, not flushing, and in_valid=1, out_valid=1 in the same cycle with out_* taken from in_* (zero latency).
  - If out_ready=1 the pair is consumed without being written.
  - If out_ready=0 it is written normally.
  - in_ready is unchanged by this feature.
- Undefined: one-cycle latency as in Behaviour; no combinational path from in_* to out_*.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t = struct {pc[PC_W], inst[INST_W]};
  - constant FQ_DEPTH_DEFAULT = 4;
  - constant PC_INCR = 4.
- Widths come from `WORD and `INST_SIZE in common.vh.
- One sub-module: fq_storage. It is a DEPTH x fetch_entry_t register array with one synchronous write port and one asynchronous read port. Pointer, flag and handshake logic stays in fetch_queue.

Test Plan:
- Fill/drain: after reset, push pc=0,4,8,12 with inst=0,1,2,3 and out_ready=0 -> in_ready=0 and count=4. Then out_ready=1 for four cycles -> out_inst=0,1,2,3, out_pc_incr=4,8,12,16, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously with pc=4k, inst=k for k=0..9 -> count stays 1 after the first edge, and out_inst follows k in order with one-cycle lag. Pointers wrap at least twice.
- Full + simultaneous pop: with count=4, assert pop and in_valid=1 together -> the push is ignored, count=3 next cycle, and in_ready=1 next cycle.
- Flush priority: count=2 with head inst=15 (pc=60); assert flush, in_valid=1 (pc=124, inst=31) and out_ready=1 together -> count=0 and out_valid=0 next cycle, and inst 31 is never delivered.
- Reset mid-operation: count=3, assert rst together with flush=0 and in_valid=1 -> count=0, out_valid=0, out_pc=0 and in_ready=1 next cycle. The next push then appears in the cycle after it.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, in_valid=1, pc=124, inst=31, out_ready=1 -> same-cycle out_valid=1, out_inst=31, out_pc_incr=128, and count remains 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue between IF and ID.
// WORD / INST_SIZE fall back to 64 / 32 when common.vh is not in the build.
`ifndef WORD
`define WORD 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

package fetch_pkg;

  localparam int FQ_PC_W          = `WORD;
  localparam int FQ_INST_W        = `INST_SIZE;
  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam int PC_INCR          = 4;

  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_EMPTY   = 2'b00,
    FQ_PARTIAL = 2'b01,
    FQ_FULL    = 2'b10
  } fq_state_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for fetch_queue: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the queue pointers.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_r [DEPTH];

  // write port: capture the entry at the tail slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH-entry {pc, inst} FIFO decoupling IF from ID stalls, with flush.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH_DEFAULT,
  parameter int PC_W   = FQ_PC_W,
  parameter int INST_W = FQ_INST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_pc_incr,
  output logic [INST_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  fq_state_t    state_s;
  logic         empty_s;
  logic         push_s;
  logic         pop_s;
  fetch_entry_t wr_entry_s;
  fetch_entry_t rd_entry_s;

  // occupancy state derived from the wrap-bit pointer comparison
  always_comb begin
    state_s = FQ_PARTIAL;
    if (wr_ptr_r == rd_ptr_r) begin
      state_s = FQ_EMPTY;
    end else if ((wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW])) begin
      state_s = FQ_FULL;
    end else begin
      state_s = FQ_PARTIAL;
    end
  end

  assign empty_s  = (state_s == FQ_EMPTY);
  assign in_ready = (state_s != FQ_FULL);
  assign count    = wr_ptr_r - rd_ptr_r;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_s;
  assign bypass_s = empty_s & ~flush & in_valid;
  // a bypassed pair that ID takes immediately is never written
  assign push_s   = in_valid & in_ready & ~flush & ~(bypass_s & out_ready);
`else
  assign push_s   = in_valid & in_ready & ~flush;
`endif
  assign pop_s    = ~empty_s & out_ready & ~flush;

  assign wr_entry_s = '{pc: in_pc, inst: in_inst};

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rd_entry_s)
  );

  // pointer update: reset over flush over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // head presentation; outputs are zero whenever nothing is valid
  always_comb begin
    out_valid   = 1'b0;
    out_pc      = {PC_W{1'b0}};
    out_pc_incr = {PC_W{1'b0}};
    out_inst    = {INST_W{1'b0}};
    if (!empty_s) begin
      out_valid   = 1'b1;
      out_pc      = rd_entry_s.pc;
      out_pc_incr = rd_entry_s.pc + PC_W'(PC_INCR);
      out_inst    = rd_entry_s.inst;
`ifdef FETCH_QUEUE_BYPASS_EN
    end else if (bypass_s) begin
      out_valid   = 1'b1;
      out_pc      = in_pc;
      out_pc_incr = in_pc + PC_W'(PC_INCR);
      out_inst    = in_inst;
`endif
    end else begin
      out_valid   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic vs a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = 64'd0;
  logic [31:0] in_inst = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [63:0] out_pc_incr;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_incr (out_pc_incr),
    .out_inst    (out_inst),
    .count       (count)
  );

  always #5 clk = ~clk;

  // reference: a plain queue updated with the handshake rules at each edge
  task automatic model_edge();
    int  n = mq.size();
    bit  do_push;
    bit  do_pop;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = out_ready && (n > 0);
      do_push = in_valid && (n < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
      if (n == 0 && in_valid && out_ready) do_push = 1'b0;
`endif
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{in_pc, in_inst});
    end
  endtask

  function automatic bit exp_valid();
    if (mq.size() > 0) return 1'b1;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!flush && in_valid) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_pc();
    if (mq.size() > 0) return mq[0].pc;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!flush && in_valid) return in_pc;
`endif
    return 64'd0;
  endfunction

  function automatic logic [31:0] exp_inst();
    if (mq.size() > 0) return mq[0].inst;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!flush && in_valid) return in_inst;
`endif
    return 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst got=%h want=0", out_inst); end
    checks++; if (out_pc_incr !== 64'd0) begin errors++; $display("FAIL reset_out_pc_incr got=%h want=0", out_pc_incr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 64'(4 * k); in_inst = 32'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d want=4", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b want=1", k, out_valid); end
      checks++; if (out_inst !== 32'(k)) begin errors++; $display("FAIL drain_inst[%0d] got=%0d want=%0d", k, out_inst, k); end
      checks++; if (out_pc_incr !== 64'(4 * k + 4)) begin errors++; $display("FAIL drain_pc_incr[%0d] got=%0d want=%0d", k, out_pc_incr, 4 * k + 4); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 64'(4 * k); in_inst = 32'(k);
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d want=1", k, count); end
      checks++; if (out_inst !== 32'(k)) begin errors++; $display("FAIL stream_inst[%0d] got=%0d want=%0d", k, out_inst, k); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got=%0d want=0", count); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 64'(400 + 4 * k); in_inst = 32'(100 + k);
      tick();
    end
    in_pc = 64'd900; in_inst = 32'd999; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready_before got=%b want=0", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got=%0d want=3", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready_after got=%b want=1", in_ready); end
    checks++; if (out_inst !== 32'd101) begin errors++; $display("FAIL fullpop_head got=%0d want=101", out_inst); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_inst !== 32'(101 + k)) begin errors++; $display("FAIL fullpop_drain[%0d] got=%0d want=%0d", k, out_inst, 101 + k); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_ignored_push got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'd60; in_inst = 32'd15; tick();
    in_pc = 64'd64; in_inst = 32'd16; tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_pre_count got=%0d want=2", count); end
    checks++; if (out_inst !== 32'd15) begin errors++; $display("FAIL flush_pre_head got=%0d want=15", out_inst); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'd124; in_inst = 32'd31; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_inst === 32'd31) begin errors++; $display("FAIL flush_leak[%0d] valid=%b inst=%0d want valid=0", k, out_valid, out_inst); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_pc = 64'(300 + 4 * k); in_inst = 32'(70 + k);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count got=%0d want=3", count); end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 64'd200; in_inst = 32'd50;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rstmid_out_pc got=%h want=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'd50) begin errors++; $display("FAIL rstmid_next_push valid=%b inst=%0d want valid=1 inst=50", out_valid, out_inst); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_drain got=%0d want=0", count); end
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1'b1; in_pc = 64'd124; in_inst = 32'd31; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b want=1", out_valid); end
    checks++; if (out_inst !== 32'd31) begin errors++; $display("FAIL bypass_inst got=%0d want=31", out_inst); end
    checks++; if (out_pc_incr !== 64'd128) begin errors++; $display("FAIL bypass_pc_incr got=%0d want=128", out_pc_incr); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count got=%0d want=0", count); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = {$urandom(), $urandom()};
      in_inst   = $urandom();
      if (c % 100 >= 60) out_ready = ($urandom_range(0, 4) == 0);
      #1;
      checks++;
      if (out_valid !== exp_valid() || out_pc !== exp_pc() || out_inst !== exp_inst() ||
          out_pc_incr !== (exp_valid() ? exp_pc() + 64'd4 : 64'd0) ||
          count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL random[%0d] got v=%b pc=%h inst=%h incr=%h cnt=%0d rdy=%b want v=%b pc=%h inst=%h cnt=%0d",
                 c, out_valid, out_pc, out_inst, out_pc_incr, count, in_ready,
                 exp_valid(), exp_pc(), exp_inst(), mq.size());
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_reset_mid();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
